// File: rtl/dac_spi_chain_if.sv
// Command / readback bus of the daisy-chained DAC serial controller.
// Ports: cmd_valid/cmd_ready handshake with cmd_rw, cmd_code, cmd_data (device k at [k*DATA_NBIT +: DATA_NBIT]);
//        rd_valid one-cycle strobe with rd_data (same packing). master = command source, slave = controller.
interface dac_spi_chain_if #(
  parameter int DATA_NBIT = 20,
  parameter int CMD_NBIT  = 3,
  parameter int NCH       = 1
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_rw;
  logic [CMD_NBIT-1:0]      cmd_code;
  logic [NCH*DATA_NBIT-1:0] cmd_data;
  logic                     rd_valid;
  logic [NCH*DATA_NBIT-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_rw, cmd_code, cmd_data,
    input  cmd_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_code, cmd_data,
    output cmd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/dac_spi_chain.sv
// Serial controller for NCH daisy-chained AD5791-class DACs: one frame per command, optional NOP readback frame, optional LDAC pulse.
// Ports: mclk/rst (sync, active high); bus = command/readback (slave modport); sclk/sdo/sync_n/ldac_n to the DAC pins, sdin from the last device; busy.
// Latency: frame starts the cycle after accept; cmd_ready only in IDLE, commands offered while busy are not queued.
module dac_spi_chain #(
  parameter int DATA_NBIT = 20,
  parameter int CMD_NBIT  = 3,
  parameter int NCH       = 1,
  parameter int SCLK_DIV  = 4,
  parameter int LDAC_AUTO = 1
) (
  input  logic            mclk,
  input  logic            rst,
  dac_spi_chain_if.slave  bus,
  output logic            sclk,
  output logic            sdo,
  input  logic            sdin,
  output logic            sync_n,
  output logic            ldac_n,
  output logic            busy
);

  localparam int FW = 1 + CMD_NBIT + DATA_NBIT;  // one device word
  localparam int FL = NCH * FW;                  // whole frame
  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(FL + 1);

  localparam logic [DW-1:0] DIV_LAST      = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF      = DW'(SCLK_DIV / 2);
  localparam logic [DW-1:0] DIV_LEAD_LAST = DW'(SCLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST      = BW'(FL - 1);
  localparam logic [CMD_NBIT-1:0] CODE_UPDATE = CMD_NBIT'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEAD, ST_SHIFT, ST_GAP, ST_RDLEAD, ST_RDSHIFT, ST_RDGAP, ST_LOAD
  } state_t;

  state_t                   state, state_nxt;
  logic [DW-1:0]            div, div_nxt;
  logic [BW-1:0]            bitcnt, bit_nxt;
  logic [FL-1:0]            sreg, sreg_nxt;
  logic [FL-1:0]            cap;
  logic [FL-1:0]            frame_in;
  logic [NCH*DATA_NBIT-1:0] rd_unpack;
  logic [NCH*DATA_NBIT-1:0] rd_data_q;
  logic                     rd_valid_q;
  logic                     rw_q;
  logic [CMD_NBIT-1:0]      code_q;
  logic                     accept;
  logic                     div_wrap;
  logic                     shifting;
  logic                     frame_nxt;
  logic                     shift_nxt;
  logic                     rd_done_nxt;

  assign bus.cmd_ready = (state == ST_IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign busy          = (state != ST_IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

  assign div_wrap  = (div == DIV_LAST);
  assign shifting  = (state == ST_SHIFT) || (state == ST_RDSHIFT);
  assign frame_nxt = (state_nxt == ST_LEAD) || (state_nxt == ST_SHIFT) ||
                     (state_nxt == ST_RDLEAD) || (state_nxt == ST_RDSHIFT);
  assign shift_nxt = (state_nxt == ST_SHIFT) || (state_nxt == ST_RDSHIFT);
  // Readback results are presented in the final RDGAP cycle.
  assign rd_done_nxt = (state_nxt == ST_RDGAP) && (div_nxt == DIV_LAST);

  // Device NCH-1 occupies the top word so it is shifted out first.
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NCH; k++) begin
      frame_in[k*FW +: FW] = {bus.cmd_rw, bus.cmd_code, bus.cmd_data[k*DATA_NBIT +: DATA_NBIT]};
    end
  end

  // The chain returns the far device first, so captured words land with the same packing.
  always_comb begin
    rd_unpack = '0;
    for (int k = 0; k < NCH; k++) begin
      rd_unpack[k*DATA_NBIT +: DATA_NBIT] = cap[k*FW +: DATA_NBIT];
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div + DW'(1);
    bit_nxt   = bitcnt;
    sreg_nxt  = sreg;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_LEAD;
          sreg_nxt  = frame_in;
        end
      end
      ST_LEAD, ST_RDLEAD: begin
        if (div == DIV_LEAD_LAST) begin
          state_nxt = (state == ST_LEAD) ? ST_SHIFT : ST_RDSHIFT;
        end
      end
      ST_SHIFT, ST_RDSHIFT: begin
        if (div_wrap) begin
          sreg_nxt = {sreg[FL-2:0], 1'b0};
          bit_nxt  = bitcnt + BW'(1);
          if (bitcnt == BIT_LAST) begin
            state_nxt = (state == ST_SHIFT) ? ST_GAP : ST_RDGAP;
          end
        end
      end
      ST_GAP: begin
        if (div_wrap) begin
          if (rw_q) begin
            state_nxt = ST_RDLEAD;
            sreg_nxt  = '0;  // NOP frame
          end else if ((LDAC_AUTO != 0) && (code_q == CODE_UPDATE)) begin
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_RDGAP, ST_LOAD: begin
        if (div_wrap) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Divider and bit count restart on every state entry: no runt sclk pulses.
    if (state_nxt != state) begin
      div_nxt = '0;
      bit_nxt = '0;
    end else if (div_wrap) begin
      div_nxt = '0;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      div        <= '0;
      bitcnt     <= '0;
      sreg       <= '0;
      cap        <= '0;
      rw_q       <= 1'b0;
      code_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sclk       <= 1'b1;
      sdo        <= 1'b0;
      sync_n     <= 1'b1;
      ldac_n     <= 1'b1;
    end else begin
      state  <= state_nxt;
      div    <= div_nxt;
      bitcnt <= bit_nxt;
      sreg   <= sreg_nxt;
      if (accept) begin
        rw_q   <= bus.cmd_rw;
        code_q <= bus.cmd_code;
      end
      // First low-half cycle of each bit is the sclk falling edge.
      if (shifting && (div == DIV_HALF)) begin
        cap <= {cap[FL-2:0], sdin};
      end
      rd_valid_q <= rd_done_nxt;
      if (rd_done_nxt) begin
        rd_data_q <= rd_unpack;
      end
      // Pin outputs are registered from next-state values so they line up with the state.
      sync_n <= !frame_nxt;
      sclk   <= !(shift_nxt && (div_nxt >= DIV_HALF));
      sdo    <= frame_nxt && sreg_nxt[FL-1];
      ldac_n <= (state_nxt != ST_LOAD);
    end
  end

endmodule

// File: tb/tb_dac_spi_chain.sv
module tb_dac_spi_chain;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        c_valid = 1'b0;
  logic        c_rw = 1'b0;
  logic [2:0]  c_code = 3'd0;
  logic [39:0] c_data = 40'h0;

  logic sclk1, sdo1, sync1, ldac1, busy1;
  logic sclk2, sdo2, sync2, ldac2, busy2;
  logic sdin_m;

  int checks = 0;
  int errors = 0;

  dac_spi_chain_if #(.DATA_NBIT(20), .CMD_NBIT(3), .NCH(1)) bus1();
  dac_spi_chain_if #(.DATA_NBIT(20), .CMD_NBIT(3), .NCH(2)) bus2();

  assign bus1.cmd_valid = c_valid & ~sel;
  assign bus1.cmd_rw    = c_rw;
  assign bus1.cmd_code  = c_code;
  assign bus1.cmd_data  = c_data[19:0];
  assign bus2.cmd_valid = c_valid & sel;
  assign bus2.cmd_rw    = c_rw;
  assign bus2.cmd_code  = c_code;
  assign bus2.cmd_data  = c_data;

  dac_spi_chain #(.DATA_NBIT(20), .CMD_NBIT(3), .NCH(1), .SCLK_DIV(4), .LDAC_AUTO(1)) dut1 (
    .mclk(mclk), .rst(rst), .bus(bus1), .sclk(sclk1), .sdo(sdo1), .sdin(sdin_m),
    .sync_n(sync1), .ldac_n(ldac1), .busy(busy1)
  );
  dac_spi_chain #(.DATA_NBIT(20), .CMD_NBIT(3), .NCH(2), .SCLK_DIV(4), .LDAC_AUTO(1)) dut2 (
    .mclk(mclk), .rst(rst), .bus(bus2), .sclk(sclk2), .sdo(sdo2), .sdin(sdin_m),
    .sync_n(sync2), .ldac_n(ldac2), .busy(busy2)
  );

  // Selected-DUT view used by the monitor.
  logic        m_sclk, m_sdo, m_sync, m_ldac, m_busy, m_rdy, m_rdv;
  logic [39:0] m_rd;
  assign m_sclk = sel ? sclk2 : sclk1;
  assign m_sdo  = sel ? sdo2  : sdo1;
  assign m_sync = sel ? sync2 : sync1;
  assign m_ldac = sel ? ldac2 : ldac1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_rdy  = sel ? bus2.cmd_ready : bus1.cmd_ready;
  assign m_rdv  = sel ? bus2.rd_valid  : bus1.rd_valid;
  assign m_rd   = sel ? bus2.rd_data   : {20'h0, bus1.rd_data};

  // Device-chain SDO model: loads its pattern on sync_n fall, advances on each sclk rise.
  logic [47:0] pat = 48'h0;
  logic [47:0] sh  = 48'h0;
  logic        ps_sync = 1'b1;
  logic        ps_sclk = 1'b1;
  always @(negedge mclk) begin
    if (ps_sync && !m_sync) sh = pat;
    else if (!m_sync && !ps_sclk && m_sclk) sh = {sh[46:0], 1'b0};
    ps_sync = m_sync;
    ps_sclk = m_sclk;
  end
  assign sdin_m = sel ? sh[47] : sh[23];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        rw;
    logic [2:0]  code;
    logic [39:0] data;
    logic [47:0] pat;
    logic [95:0] bits;   // every sdo bit seen at sclk falls, first bit highest
    int          falls;
    int          sf, sl, sc;   // sync_n low: first cycle, last cycle, cycle count
    int          lf, lc;       // ldac_n low: first cycle, cycle count
    int          rdy;          // first cycle cmd_ready returns
    int          rdv, rdc;     // rd_valid pulse count, cycle of pulse
    logic [39:0] rd;           // rd_data at end of window
  } vec_t;

  vec_t tab[7];

  // Issue one command (accept cycle = 0) and observe 410 cycles.
  task automatic run_vec(input int idx, input vec_t v);
    int falls, sf, sl, sc, lf, lc, rdy, rdv, rdc, glitch, busy_err, waitc;
    logic [95:0] bits;
    logic psclk;
    @(negedge mclk);
    sel = v.sel; pat = v.pat;
    c_valid = 1'b1; c_rw = v.rw; c_code = v.code; c_data = v.data;
    #1;
    waitc = 0;
    while (!m_rdy && waitc < 1000) begin
      @(negedge mclk);
      waitc++;
    end
    if (!m_rdy) begin
      chk_int($sformatf("v%0d_accept_timeout", idx), 0, 1);
      c_valid = 1'b0;
      return;
    end
    @(posedge mclk); #1;
    c_valid = 1'b0;
    falls = 0; sf = -1; sl = -1; sc = 0; lf = -1; lc = 0; rdy = -1; rdv = 0; rdc = -1;
    glitch = 0; busy_err = 0; bits = '0; psclk = 1'b1;
    for (int c = 1; c <= 410; c++) begin
      @(negedge mclk);
      if (!m_sync) begin
        if (sf < 0) sf = c;
        sl = c;
        sc++;
      end
      if (!m_ldac) begin
        if (lf < 0) lf = c;
        lc++;
      end
      if (psclk && !m_sclk) begin
        bits = {bits[94:0], m_sdo};
        falls++;
      end
      if (m_sync && !m_sclk) glitch++;
      if (m_rdv) begin
        rdv++;
        rdc = c;
      end
      if (m_rdy && rdy < 0) rdy = c;
      if (m_busy != (rdy < 0)) busy_err++;
      psclk = m_sclk;
    end
    chk($sformatf("v%0d_sdo_bits", idx), bits, v.bits);
    chk_int($sformatf("v%0d_sclk_falls", idx), falls, v.falls);
    chk_int($sformatf("v%0d_sync_first", idx), sf, v.sf);
    chk_int($sformatf("v%0d_sync_last", idx), sl, v.sl);
    chk_int($sformatf("v%0d_sync_count", idx), sc, v.sc);
    chk_int($sformatf("v%0d_ldac_first", idx), lf, v.lf);
    chk_int($sformatf("v%0d_ldac_count", idx), lc, v.lc);
    chk_int($sformatf("v%0d_ready_cycle", idx), rdy, v.rdy);
    chk_int($sformatf("v%0d_rd_valid_count", idx), rdv, v.rdv);
    chk_int($sformatf("v%0d_rd_valid_cycle", idx), rdc, v.rdc);
    chk($sformatf("v%0d_rd_data", idx), {56'h0, m_rd}, {56'h0, v.rd});
    chk_int($sformatf("v%0d_sclk_while_sync_high", idx), glitch, 0);
    chk_int($sformatf("v%0d_busy_mismatch", idx), busy_err, 0);
  endtask

  initial begin
    int waitc, n, nf, ldac_seen, rdv_seen, busy_seen;
    int acc_cyc[8];
    logic [19:0] acc_dat[8];
    logic [23:0] frames[8];
    logic [23:0] word;
    logic [19:0] base;
    logic psclk, psync, acc;

    tab[0] = '{1'b0, 1'b0, 3'd1, 40'h12345, 48'h0, 96'h112345, 24, 1, 98, 98, 103, 4, 107, 0, -1, 40'h0};
    tab[1] = '{1'b0, 1'b0, 3'd2, 40'h12345, 48'h0, 96'h212345, 24, 1, 98, 98, -1, 0, 103, 0, -1, 40'h0};
    tab[2] = '{1'b0, 1'b1, 3'd1, 40'h12345, 48'h1ABCDE, 96'h912345000000, 48, 1, 200, 196, -1, 0, 205, 1, 204, 40'hABCDE};
    tab[3] = '{1'b0, 1'b0, 3'd7, 40'h0, 48'h0, 96'h700000, 24, 1, 98, 98, -1, 0, 103, 0, -1, 40'hABCDE};
    tab[4] = '{1'b0, 1'b1, 3'd0, 40'hFFFFF, 48'hF00001, 96'h8FFFFF000000, 48, 1, 200, 196, -1, 0, 205, 1, 204, 40'h00001};
    tab[5] = '{1'b1, 1'b0, 3'd1, 40'h00001FFFFF, 48'h0, 96'h1000011FFFFF, 48, 1, 194, 194, 199, 4, 203, 0, -1, 40'h0};
    tab[6] = '{1'b1, 1'b1, 3'd0, 40'h0, 48'h0AAAAA155555, 96'h800000800000000000000000, 96, 1, 392, 388, -1, 0, 397, 1, 396, 40'hAAAAA55555};

    // Reset values.
    repeat (3) @(negedge mclk);
    chk("rst_sync_n", {95'h0, sync1}, 96'h1);
    chk("rst_ldac_n", {95'h0, ldac1}, 96'h1);
    chk("rst_sclk", {95'h0, sclk1}, 96'h1);
    chk("rst_sdo", {95'h0, sdo1}, 96'h0);
    chk("rst_cmd_ready", {95'h0, bus1.cmd_ready}, 96'h0);
    chk("rst_rd_valid", {95'h0, bus1.rd_valid}, 96'h0);
    chk("rst_rd_data", {76'h0, bus1.rd_data}, 96'h0);
    chk("rst_busy", {95'h0, busy1}, 96'h0);
    chk("rst_sync_n_chain", {95'h0, sync2}, 96'h1);
    chk("rst_busy_chain", {95'h0, busy2}, 96'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", {95'h0, bus1.cmd_ready}, 96'h1);

    for (int i = 0; i < 7; i++) run_vec(i, tab[i]);

    // Reset during SHIFT bit 10 of a write with LDAC.
    @(negedge mclk);
    sel = 1'b0; c_valid = 1'b1; c_rw = 1'b0; c_code = 3'd1; c_data = 40'h12345;
    #1;
    waitc = 0;
    while (!m_rdy && waitc < 1000) begin
      @(negedge mclk);
      waitc++;
    end
    chk("abort_accepted", {95'h0, m_rdy}, 96'h1);
    @(posedge mclk); #1;
    c_valid = 1'b0;
    repeat (43) @(negedge mclk);   // cycle 43 = first cycle of bit 10
    chk("abort_in_frame_sync", {95'h0, sync1}, 96'h0);
    chk("abort_in_frame_sclk", {95'h0, sclk1}, 96'h1);
    rst = 1'b1;
    @(negedge mclk);
    chk("abort_sync_n", {95'h0, sync1}, 96'h1);
    chk("abort_sclk", {95'h0, sclk1}, 96'h1);
    chk("abort_busy", {95'h0, busy1}, 96'h0);
    chk("abort_sdo", {95'h0, sdo1}, 96'h0);
    chk("abort_rd_data", {76'h0, bus1.rd_data}, 96'h0);
    chk("abort_ready_in_rst", {95'h0, bus1.cmd_ready}, 96'h0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {95'h0, bus1.cmd_ready}, 96'h1);
    ldac_seen = 0; rdv_seen = 0; busy_seen = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge mclk);
      if (!ldac1) ldac_seen++;
      if (bus1.rd_valid) rdv_seen++;
      if (busy1) busy_seen++;
    end
    chk_int("abort_no_ldac", ldac_seen, 0);
    chk_int("abort_no_rd_valid", rdv_seen, 0);
    chk_int("abort_stays_idle", busy_seen, 0);
    run_vec(7, tab[0]);

    // cmd_valid held high with incrementing data.
    @(negedge mclk);
    sel = 1'b0; c_rw = 1'b0; c_code = 3'd2; base = 20'h00100;
    c_data = {20'h0, base}; c_valid = 1'b1;
    n = 0; nf = 0; word = '0; psclk = 1'b1; psync = 1'b1;
    for (int c = 0; c < 450; c++) begin
      if (c > 0) @(negedge mclk);
      acc = m_rdy && c_valid;
      if (acc) begin
        if (n < 8) begin
          acc_cyc[n] = c;
          acc_dat[n] = c_data[19:0];
        end
        n++;
      end
      if (psclk && !m_sclk) word = {word[22:0], m_sdo};
      if (!psync && m_sync) begin
        if (nf < 8) frames[nf] = word;
        nf++;
      end
      psclk = m_sclk;
      psync = m_sync;
      @(posedge mclk); #1;
      if (acc) begin
        c_data = c_data + 40'h1;
        if (n == 4) c_valid = 1'b0;
      end
    end
    chk_int("stream_accepts", n, 4);
    chk_int("stream_frames", nf, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) chk($sformatf("stream_accept_data%0d", i), {76'h0, acc_dat[i]}, {76'h0, base + 20'(i)});
      if (i < nf) chk($sformatf("stream_frame%0d", i), {72'h0, frames[i]}, {72'h0, 4'h2, base + 20'(i)});
      if (i > 0 && i < n) chk_int($sformatf("stream_interval%0d", i), acc_cyc[i] - acc_cyc[i-1], 103);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
